// File: rtl/crc_trans.sv
// crc_trans: appends a CRC-32 (reflected, poly 0x04C11DB7) after every FRAME_LEN
// payload words. Macro CRC_TRANS_FINAL_XOR_EN selects init/final-xor 0xFFFFFFFF.
// Ports: axis_aclk, axis_aresetn (async, active low), data_in/data_in_valid in,
//        data_out (registered payload or CRC), frame_ready (1-cycle CRC strobe).
module crc_trans #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 4
) (
  input  logic                  axis_aclk,
  input  logic                  axis_aresetn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_ready
);

`ifdef CRC_TRANS_FINAL_XOR_EN
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOR  = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CRC_INIT = 32'h0000_0000;
  localparam logic [31:0] CRC_XOR  = 32'h0000_0000;
`endif

  localparam logic [31:0] POLY_R = 32'hEDB8_8320;
  localparam logic [15:0] LAST   = 16'(FRAME_LEN - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    APPEND  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [31:0]           crc_q, crc_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  fr_q, fr_d;
  logic [1:0]            sync_q;
  logic                  run;

  // Bit 0 of the word enters first: bytes LSB-first, each byte LSB-first,
  // which in the reflected register is just a right-shift over bits 0..31.
  function automatic logic [31:0] crc_fold(
    input logic [31:0]           c,
    input logic [DATA_WIDTH-1:0] w
  );
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      fb = r[0] ^ w[i];
      r  = r >> 1;
      if (fb) r = r ^ POLY_R;
    end
    return r;
  endfunction

  // Reset release is synchronized; the core only runs two edges later.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign run = sync_q[1];

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      crc_q   <= CRC_INIT;
      dout_q  <= '0;
      fr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      dout_q  <= dout_d;
      fr_q    <= fr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    dout_d  = dout_q;
    fr_d    = 1'b0;
    if (run) begin
      unique case (state_q)
        COLLECT: begin
          if (data_in_valid) begin
            dout_d = data_in;
            crc_d  = crc_fold(crc_q, data_in);
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = APPEND;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        APPEND: begin
          // Input in this cycle is dropped on purpose.
          dout_d  = DATA_WIDTH'(crc_q ^ CRC_XOR);
          fr_d    = 1'b1;
          crc_d   = CRC_INIT;
          state_d = COLLECT;
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  assign data_out    = dout_q;
  assign frame_ready = fr_q;

endmodule

// File: tb/tb_crc_trans.sv
// tb_crc_trans: scoreboard bench for crc_trans (FRAME_LEN=1 and FRAME_LEN=4).
// Expected words are queued per cycle; per-DUT monitors pop and compare.
module tb_crc_trans;

`ifdef CRC_TRANS_FINAL_XOR_EN
  localparam logic [31:0] INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] FX   = 32'hFFFF_FFFF;
  localparam logic [31:0] C0   = 32'h2144_DF1C;
  localparam logic [31:0] CF   = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] INIT = 32'h0000_0000;
  localparam logic [31:0] FX   = 32'h0000_0000;
  localparam logic [31:0] C0   = 32'h0000_0000;
  localparam logic [31:0] CF   = 32'hDEBB_20E3;
`endif

  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic        fr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] d1 = '0, d4 = '0;
  logic        v1 = 1'b0, v4 = 1'b0;
  logic [31:0] o1, o4;
  logic        f1, f4;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q1[$];
  exp_t        q4[$];

  int          m_cnt;
  logic [31:0] m_crc;
  logic [31:0] m_last;
  logic        m_app;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc_trans #(.DATA_WIDTH(32), .FRAME_LEN(1)) u1 (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .data_in(d1), .data_in_valid(v1),
    .data_out(o1), .frame_ready(f1)
  );

  crc_trans #(.DATA_WIDTH(32), .FRAME_LEN(4)) u4 (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .data_in(d4), .data_in_valid(v4),
    .data_out(o4), .frame_ready(f4)
  );

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // Non-reflected MSB-first formulation with explicit bit reversal.
  function automatic logic [31:0] ref_crc(input logic [31:0] c,
                                          input logic [31:0] w);
    logic [31:0] r;
    logic [7:0]  b;
    logic        fb;
    r = rev32(c);
    for (int k = 0; k < 4; k++) begin
      b = w[8*k +: 8];
      for (int i = 0; i < 8; i++) begin
        fb = r[31] ^ b[i];
        r  = r << 1;
        if (fb) r = r ^ 32'h04C1_1DB7;
      end
    end
    return rev32(r);
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_crc  = INIT;
    m_last = '0;
    m_app  = 1'b0;
  endtask

  // One cycle on the FRAME_LEN=4 DUT; call at a negedge.
  task automatic step4(input logic v, input logic [31:0] d);
    exp_t e;
    e.cyc = cyc + 1;
    e.fr  = 1'b0;
    if (m_app) begin
      e.d   = m_crc ^ FX;
      e.fr  = 1'b1;
      m_crc = INIT;
      m_app = 1'b0;
    end else if (v) begin
      e.d   = d;
      m_crc = ref_crc(m_crc, d);
      m_cnt = m_cnt + 1;
      if (m_cnt == 4) begin
        m_cnt = 0;
        m_app = 1'b1;
      end
    end else begin
      e.d = m_last;
    end
    m_last = e.d;
    q4.push_back(e);
    v4 = v;
    d4 = d;
    @(negedge clk);
  endtask

  // One single-word frame on the FRAME_LEN=1 DUT with hand CRC.
  task automatic frame1(input logic [31:0] w, input logic [31:0] c);
    q1.push_back('{cyc + 1, w, 1'b0});
    v1 = 1'b1;
    d1 = w;
    @(negedge clk);
    q1.push_back('{cyc + 1, c, 1'b1});
    v1 = 1'b0;
    @(negedge clk);
    q1.push_back('{cyc + 1, c, 1'b0});
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic hit;
    hit = 1'b0;
    while (q1.size() > 0 && q1[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL n1_missed cyc=%0d", q1[0].cyc);
      void'(q1.pop_front());
    end
    if (q1.size() > 0 && q1[0].cyc == cyc) begin
      e = q1.pop_front();
      hit = 1'b1;
      checks++;
      if (o1 !== e.d || f1 !== e.fr) begin
        errors++;
        $display("FAIL n1_out cyc=%0d got %h/%b want %h/%b",
                 cyc, o1, f1, e.d, e.fr);
      end
    end
    if (!hit && f1 === 1'b1) begin
      checks++; errors++;
      $display("FAIL n1_spurious_ready cyc=%0d got 1 want 0", cyc);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic hit;
    hit = 1'b0;
    while (q4.size() > 0 && q4[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL n4_missed cyc=%0d", q4[0].cyc);
      void'(q4.pop_front());
    end
    if (q4.size() > 0 && q4[0].cyc == cyc) begin
      e = q4.pop_front();
      hit = 1'b1;
      checks++;
      if (o4 !== e.d || f4 !== e.fr) begin
        errors++;
        $display("FAIL n4_out cyc=%0d got %h/%b want %h/%b",
                 cyc, o4, f4, e.d, e.fr);
      end
    end
    if (!hit && f4 === 1'b1) begin
      checks++; errors++;
      $display("FAIL n4_spurious_ready cyc=%0d got 1 want 0", cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk_reset(input string nm);
    checks++;
    if (o1 !== 32'h0 || f1 !== 1'b0 || o4 !== 32'h0 || f4 !== 1'b0) begin
      errors++;
      $display("FAIL %s got %h/%b %h/%b want 0/0", nm, o1, f1, o4, f4);
    end
  endtask

  initial begin
    model_reset();
    v1 = 1'b1; d1 = 32'hDEAD_BEEF;
    v4 = 1'b1; d4 = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    chk_reset("reset_state");
    v1 = 1'b0; v4 = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    frame1(32'h0000_0000, C0);
    frame1(32'hFFFF_FFFF, CF);

    step4(1, 5);
    step4(1, 3);
    step4(1, 678);
    step4(1, 76);
    step4(1, 89);
    step4(0, 0);
    step4(0, 0);

    step4(1, 1);
    step4(1, 2);
    step4(1, 3);
    step4(1, 4);
    step4(0, 0);
    step4(0, 0);

    step4(1, 1);
    step4(0, 0);
    step4(1, 2);
    step4(0, 0);
    step4(1, 3);
    step4(0, 0);
    step4(1, 4);
    step4(0, 0);
    step4(0, 0);
    step4(0, 0);

    step4(1, 7);
    step4(1, 8);
    v4 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    v4 = 1'b1; d4 = 32'h1234_5678;
    @(negedge clk);
    chk_reset("midframe_reset");
    model_reset();
    v4 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    step4(1, 1);
    step4(1, 2);
    step4(1, 3);
    step4(1, 4);
    step4(0, 0);
    step4(0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (q1.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL queues_drained got %0d/%0d want 0/0",
               q1.size(), q4.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
